// File: rtl/frame_uart_sender.sv
// rtl/frame_uart_sender.sv - streams a frame buffer out as framed 8N1 UART bytes
// Sync header, MSB-first zero-padded pixels, optional additive checksum; assumes CLK_FREQ/BAUD >= 2.
module frame_uart_sender #(
   parameter int         CLK_FREQ    = 50_000_000,
   parameter int         BAUD        = 9600,
   parameter int         PIXEL_W     = 12,
   parameter int         NUM_PIXELS  = 76800,
   parameter int         ADDR_W      = 17,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter bit         CHECKSUM_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [PIXEL_W-1:0] pixel,
   output logic [ADDR_W-1:0] address,
   output logic              uart_out,
   output logic              busy,
   output logic              frame_done
);
   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int NB  = (PIXEL_W + 7) / 8;
   localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
   localparam int PW  = 8 * NB;
   localparam logic [CW-1:0]     LAST_CLK  = CW'(CPB - 1);
   localparam logic [CW-1:0]     PRE_CLK   = CW'(CPB - 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [IW-1:0]     TOP_IDX   = IW'(NB - 1);

   typedef enum logic [2:0] {IDLE, HEADER, FETCH, PIXEL, CHECKSUM, DONE} state_t;

   state_t            state_q;
   logic [CW-1:0]     clk_cnt_q;
   logic [3:0]        bit_cnt_q;
   logic [7:0]        tx_byte_q;
   logic [IW-1:0]     byte_idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [PIXEL_W-1:0] pix_q;
   logic [7:0]        csum_q;
   logic              uart_q, busy_q, done_q, abort_q, load_q;

   logic [PW-1:0] pix_in_ext, pix_ext, pix_sh;
   logic [IW-1:0] nxt_idx;
   logic [7:0]    top_byte, pix_byte;
   logic          bit_end, stop_bit, byte_end, pre_last, abort_now, finish;

   assign pix_in_ext = PW'(pixel);
   assign pix_ext    = PW'(pix_q);
   assign nxt_idx    = byte_idx_q - 1'b1;
   assign pix_sh     = pix_ext >> {nxt_idx, 3'b000};
   assign pix_byte   = pix_sh[7:0];
   assign top_byte   = pix_in_ext[PW-1 -: 8];
   assign bit_end    = (clk_cnt_q == LAST_CLK);
   assign stop_bit   = (bit_cnt_q == 4'd9);
   assign byte_end   = bit_end && stop_bit;
   assign pre_last   = stop_bit && (clk_cnt_q == PRE_CLK);
   assign abort_now  = abort || abort_q;
   // PIXEL with index 0 only reaches byte_end on the last pixel; earlier pixels divert to FETCH.
   assign finish     = (state_q == CHECKSUM) || abort_now ||
                       (state_q == PIXEL && byte_idx_q == '0 && !CHECKSUM_EN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         tx_byte_q  <= '0;
         byte_idx_q <= '0;
         addr_q     <= '0;
         pix_q      <= '0;
         csum_q     <= '0;
         uart_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
         load_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= HEADER;
                  busy_q     <= 1'b1;
                  uart_q     <= 1'b0;
                  clk_cnt_q  <= '0;
                  bit_cnt_q  <= '0;
                  tx_byte_q  <= SYNC_BYTE;
                  csum_q     <= SYNC_BYTE;
                  byte_idx_q <= '0;
                  abort_q    <= 1'b0;
               end
            end
            DONE: begin
               state_q    <= IDLE;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               addr_q     <= '0;
               csum_q     <= '0;
               byte_idx_q <= '0;
               abort_q    <= 1'b0;
            end
            default: begin
               if (abort) abort_q <= 1'b1;
               // Pixel data arrives one cycle into its first start bit, well before data bit 0.
               if (load_q) begin
                  load_q    <= 1'b0;
                  pix_q     <= pixel;
                  tx_byte_q <= top_byte;
                  csum_q    <= csum_q + top_byte;
               end
               if (!bit_end) begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end else begin
                  clk_cnt_q <= '0;
                  if (!stop_bit) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     uart_q    <= (bit_cnt_q == 4'd8) ? 1'b1 : tx_byte_q[bit_cnt_q[2:0]];
                  end
               end
               if (pre_last && ((state_q == HEADER && byte_idx_q == IW'(1)) ||
                                (state_q == PIXEL && byte_idx_q == '0 && addr_q != LAST_ADDR))) begin
                  state_q <= FETCH;
                  if (state_q == PIXEL) addr_q <= addr_q + 1'b1;
               end
               if (byte_end) begin
                  bit_cnt_q <= '0;
                  if (finish) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     uart_q <= 1'b0;
                     case (state_q)
                        HEADER: begin
                           tx_byte_q  <= ~SYNC_BYTE;
                           csum_q     <= csum_q + ~SYNC_BYTE;
                           byte_idx_q <= IW'(1);
                        end
                        FETCH: begin
                           state_q    <= PIXEL;
                           byte_idx_q <= TOP_IDX;
                           load_q     <= 1'b1;
                        end
                        PIXEL: begin
                           if (byte_idx_q != '0) begin
                              byte_idx_q <= nxt_idx;
                              tx_byte_q  <= pix_byte;
                              csum_q     <= csum_q + pix_byte;
                           end else begin
                              state_q   <= CHECKSUM;
                              tx_byte_q <= csum_q;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign address    = addr_q;
   assign uart_out   = uart_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
endmodule

// File: doc/frame_uart_sender.md
FRAME_UART_SENDER -- requirements
Module: frame_uart_sender

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division.
REQ-003 SHALL have parameter PIXEL_W, default 12, pixel width in bits, range 1..32.
REQ-004 SHALL have parameter NUM_PIXELS, default 76800, number of pixels per frame, minimum 1.
REQ-005 SHALL have parameter ADDR_W, default 17, address width; 2**ADDR_W >= NUM_PIXELS.
REQ-006 SHALL have parameter SYNC_BYTE, default 8'hA5, first header byte.
REQ-007 SHALL have parameter CHECKSUM_EN, default 1, appends a checksum byte when 1.
REQ-008 Ports: clk  input  1  system clock; all logic on its rising edge.
REQ-009 Ports: rst_n  input  1  asynchronous, active-low reset.
REQ-010 Ports: start  input  1  single-cycle request to send one frame.
REQ-011 Ports: abort  input  1  request to stop the frame early.
REQ-012 Ports: pixel  input  PIXEL_W  pixel data; frame-buffer read data, valid 1 cycle after address.
REQ-013 Ports: address  output  ADDR_W  frame-buffer read address.
REQ-014 Ports: uart_out  output  1  serial line; idles high.
REQ-015 Ports: busy  output  1  high from the cycle after start is accepted until the frame ends.
REQ-016 Ports: frame_done  output  1  one-cycle pulse when a frame completes or is aborted.

Function
REQ-017 States SHALL be IDLE, HEADER, FETCH, PIXEL, CHECKSUM, DONE.
REQ-018 IDLE: start=1 SHALL move to HEADER and set busy=1 next cycle; start SHALL be ignored outside IDLE.
REQ-019 Byte format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each CLKS_PER_BIT cycles long.
REQ-020 Consecutive bytes within a frame SHALL be sent back-to-back, with no idle gap between stop and start bits.
REQ-021 HEADER SHALL send SYNC_BYTE, then ~SYNC_BYTE.
REQ-022 FETCH SHALL drive the next address and wait exactly 1 cycle; the pixel SHALL be registered on the following edge.
  - FETCH SHALL overlap the final stop-bit cycle of the previous byte so that REQ-020 holds.
REQ-023 Each pixel SHALL be sent as B = ceil(PIXEL_W/8) bytes, most-significant byte first, zero-padded in the MSBs.
  - Example: PIXEL_W=12 -> {4'b0,p[11:8]}, then p[7:0].
REQ-024 address SHALL step 0..NUM_PIXELS-1 without skipping or repeating; after the last pixel, the next state SHALL be CHECKSUM if CHECKSUM_EN, else DONE.
REQ-025 Checksum SHALL be the 8-bit sum, modulo 256, of every byte sent including the header; it SHALL not include itself.
REQ-026 DONE SHALL last one cycle: frame_done=1, busy=0 next cycle, address returns to 0, then IDLE.
REQ-027 On abort=1 while busy, the current byte SHALL finish including its stop bit, then the block SHALL go to DONE.
  - The checksum SHALL be skipped.
  - abort SHALL be ignored in IDLE.
REQ-028 abort and the last stop bit in the same cycle SHALL be treated as normal completion; one frame_done pulse only.
REQ-029 start in the same cycle as frame_done SHALL be ignored; a new start is accepted once in IDLE.
REQ-030 Bit and byte counters SHALL be sized from the parameters; no overflow for NUM_PIXELS = 2**ADDR_W.

Reset
REQ-031 rst_n=0 SHALL force the following immediately, regardless of clk, including mid-byte:
  - state=IDLE, uart_out=1, busy=0, frame_done=0, address=0;
  - all counters and the checksum = 0.
REQ-032 After rst_n deasserts, the block SHALL wait in IDLE for start; no partial frame SHALL resume.

Verification
Bench parameters: CLK_FREQ=40, BAUD=10 (4 clocks/bit), NUM_PIXELS=4, PIXEL_W=12; memory returns pixel[a]=0x100+a with 1-cycle latency.
REQ-033 Nominal frame: pulse start.
  - Decoded bytes SHALL be A5 5A 01 00 01 01 01 02 01 03 09.
  - frame_done SHALL pulse 440 cycles after busy rises.
REQ-034 CHECKSUM_EN=0: same stimulus -> 10 bytes, ending 01 03; frame_done at 400 cycles.
REQ-035 Abort: assert abort during pixel 1, high byte -> that byte completes; no further bytes; frame_done once; uart_out=1 after.
REQ-036 Reset mid-byte: drop rst_n during bit 3 of byte 2 -> uart_out=1, busy=0, address=0 immediately; after release a fresh start gives the full nominal sequence.
REQ-037 Start ignored while busy: pulse start again at cycle 100 -> exactly 11 bytes, one frame_done; address never exceeds 3; no gaps between bytes.
